slb_issue: RTL and testbench

- Load/store request issuer: the requesting end of the byte-serial dcache request/response interface.
- Buffers memory ops from dispatch in a circular FIFO and issues them to dcache one at a time.
- Stores are posted; loads wait for the tagged response, which is size-formatted and sign/zero-extended.
- Each load result is broadcast on a one-cycle result bus to the ROB/RS.

---
 rtl/slb_issue_pkg.sv | 50 +++++
 rtl/slb_fifo.sv | 73 +++++++
 rtl/slb_issue.sv | 196 +++++++++++++++++++
 tb/tb_slb_issue.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slb_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : slb_issue_pkg
//  Purpose : Shared definitions for the load/store request issuer: size
//            codes, ROB tag width, FSM state encoding, the buffered memory-op
//            record and the load-result formatting function.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package slb_issue_pkg;

  localparam int TAG_W = 5;

  // Access size codes; code 3 is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Issuer FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One buffered memory operation
  typedef struct packed {
    logic [TAG_W-1:0] entry;
    logic             wr;
    logic [1:0]       size;
    logic             sgn;
    logic [31:0]      addr;
    logic [31:0]      data;
  } mem_op_t;

  // Extract the accessed bytes of a little-endian response and extend them
  // to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [1:0]  size,
                                           input logic        sgn,
                                           input logic [31:0] raw);
    logic [31:0] v;
    case (size)
      SZ_BYTE: v = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_HALF: v = {{16{sgn & raw[15]}}, raw[15:0]};
      SZ_WORD: v = raw;
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slb_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : slb_fifo
//  Purpose : Circular buffer of memory ops with push, pop and flush.
//  Ports   : clk, rst_n       - clock, asynchronous active-low reset
//            i_en             - global advance enable (low = hold all state)
//            i_flush          - drop all entries (head catches up to tail)
//            i_push, i_data   - write one op at the tail
//            i_pop            - retire the op at the head
//            o_head           - op at the head (valid when !o_empty)
//            o_count          - number of stored ops
//            o_full, o_empty  - occupancy flags
//  Revision: 1.0 - initial release
// ============================================================================
module slb_fifo
  import slb_issue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  mem_op_t                i_data,
  input  logic                   i_pop,
  output mem_op_t                o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  mem_op_t         r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        if (i_push) r_tail <= r_tail + 1'b1;
        if (i_pop)  r_head <= r_head + 1'b1;
        case ({i_push, i_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (i_en && i_push && !i_flush) r_mem[r_tail] <= i_data;
  end

  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/slb_issue.sv
`default_nettype none
// ============================================================================
//  Module  : slb_issue
//  Purpose : Load/store request issuer. Buffers memory ops from dispatch,
//            issues them one at a time to the dcache, posts stores, waits
//            for tagged load responses and broadcasts formatted load results
//            on a one-cycle result bus.
//  Ports   : clk_in, rst_in   - clock, asynchronous active-low reset
//            rdy_in           - global stall (low = hold everything)
//            clear            - misprediction flush
//            push_*           - op enqueue from dispatch; full = no room
//            req_*            - one-cycle request pulse to dcache
//            resp_*           - load data returned by dcache
//            cdb_*            - one-cycle load result broadcast
//  Revision: 1.0 - initial release
// ============================================================================
module slb_issue #(
  parameter int DEPTH        = 16,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        push_valid,
  input  logic [4:0]  push_entry,
  input  logic        push_wr,
  input  logic [1:0]  push_size,
  input  logic        push_signed,
  input  logic [31:0] push_addr,
  input  logic [31:0] push_data,
  output logic        full,
  output logic        req_valid,
  output logic [4:0]  req_entry,
  output logic        req_wr,
  output logic [1:0]  req_size,
  output logic [31:0] req_addr,
  output logic [31:0] req_data,
  input  logic        resp_valid,
  input  logic [4:0]  resp_entry,
  input  logic [31:0] resp_data,
  output logic        cdb_valid,
  output logic [4:0]  cdb_entry,
  output logic [31:0] cdb_value
);

  import slb_issue_pkg::*;

  localparam int             DCW        = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  logic [1:0]             r_state;
  logic [DCW-1:0]         r_drain_cnt;
  logic [TAG_W-1:0]       r_tag;
  logic [1:0]             r_size;
  logic                   r_sgn;
  logic                   r_req_valid;
  logic [4:0]             r_req_entry;
  logic                   r_req_wr;
  logic [1:0]             r_req_size;
  logic [31:0]            r_req_addr;
  logic [31:0]            r_req_data;
  logic                   r_cdb_valid;
  logic [4:0]             r_cdb_entry;
  logic [31:0]            r_cdb_value;

  mem_op_t                w_push_op;
  mem_op_t                w_head;
  mem_op_t                w_op;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_can_issue;
  logic                   w_pop;
  logic                   w_push_acc;
  logic                   w_bypass;
  logic                   w_issue;
  logic                   w_fifo_push;

  always_comb begin
    w_push_op.entry = push_entry;
    w_push_op.wr    = push_wr;
    w_push_op.size  = push_size;
    w_push_op.sgn   = push_signed;
    w_push_op.addr  = push_addr;
    w_push_op.data  = push_data;
  end

  // A request is held for one cycle, so a new one may be launched only when
  // the previous pulse has dropped.
  assign w_can_issue = (r_state == ST_IDLE) && !r_req_valid && !clear;
  assign w_pop       = w_can_issue && (w_count != '0);
  // When full, a push is still taken if the head leaves in the same cycle,
  // so the occupancy stays at DEPTH.
  assign w_push_acc  = push_valid && !clear && (!w_full || w_pop);
  // An op pushed into an empty buffer is issued straight from the push port,
  // giving a request on the cycle right after the push.
  assign w_bypass    = w_can_issue && w_empty && w_push_acc;
  assign w_issue     = w_pop || w_bypass;
  assign w_fifo_push = w_push_acc && !w_bypass;
  assign w_op        = w_empty ? w_push_op : w_head;

  slb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .i_en    (rdy_in),
    .i_flush (clear),
    .i_push  (w_fifo_push),
    .i_data  (w_push_op),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_tag       <= '0;
      r_size      <= '0;
      r_sgn       <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_entry <= '0;
      r_req_wr    <= 1'b0;
      r_req_size  <= '0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_entry <= '0;
      r_cdb_value <= '0;
    end else if (rdy_in) begin
      r_req_valid <= 1'b0;
      r_cdb_valid <= 1'b0;

      // w_issue implies ST_IDLE, so it never competes with the case below.
      if (w_issue) begin
        r_req_valid <= 1'b1;
        r_req_entry <= w_op.entry;
        r_req_wr    <= w_op.wr;
        r_req_size  <= w_op.size;
        r_req_addr  <= w_op.addr;
        r_req_data  <= w_op.wr ? w_op.data : 32'h0;
        if (!w_op.wr) begin
          r_state <= ST_WAIT;
          r_tag   <= w_op.entry;
          r_size  <= w_op.size;
          r_sgn   <= w_op.sgn;
        end
      end

      case (r_state)
        ST_WAIT: begin
          if (clear) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end else if (resp_valid && (resp_entry == r_tag)) begin
            r_cdb_valid <= 1'b1;
            r_cdb_entry <= r_tag;
            r_cdb_value <= fmt_load(r_size, r_sgn, resp_data);
            r_state     <= ST_IDLE;
          end
        end
        // The flushed load's response may still arrive; swallow it, or give
        // up after DRAIN_CYCLES.
        ST_DRAIN: begin
          if (clear) begin
            r_drain_cnt <= '0;
          end else if (resp_valid || (r_drain_cnt == DRAIN_LAST)) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign full      = w_full;
  assign req_valid = r_req_valid;
  assign req_entry = r_req_entry;
  assign req_wr    = r_req_wr;
  assign req_size  = r_req_size;
  assign req_addr  = r_req_addr;
  assign req_data  = r_req_data;
  assign cdb_valid = r_cdb_valid;
  assign cdb_entry = r_cdb_entry;
  assign cdb_value = r_cdb_value;

endmodule
`default_nettype wire

// File: tb/tb_slb_issue.sv
`default_nettype none
// ============================================================================
//  Module  : tb_slb_issue
//  Purpose : Scoreboard bench for slb_issue. Directed stimulus queues the
//            expected requests/results (with their cycle numbers); a monitor
//            on the falling edge pops and compares every pulse it sees.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_slb_issue;
  import slb_issue_pkg::*;

  logic        clk_in      = 1'b0;
  logic        rst_in      = 1'b1;
  logic        rdy_in      = 1'b1;
  logic        clear       = 1'b0;
  logic        push_valid  = 1'b0;
  logic [4:0]  push_entry  = '0;
  logic        push_wr     = 1'b0;
  logic [1:0]  push_size   = '0;
  logic        push_signed = 1'b0;
  logic [31:0] push_addr   = '0;
  logic [31:0] push_data   = '0;
  logic        resp_valid  = 1'b0;
  logic [4:0]  resp_entry  = '0;
  logic [31:0] resp_data   = '0;
  logic        full;
  logic        req_valid;
  logic [4:0]  req_entry;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        cdb_valid;
  logic [4:0]  cdb_entry;
  logic [31:0] cdb_value;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0]  entry;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_req_t;

  typedef struct {
    logic [4:0]  entry;
    logic [31:0] value;
    int          cyc;
  } exp_cdb_t;

  exp_req_t req_q[$];
  exp_cdb_t cdb_q[$];

  slb_issue #(.DEPTH(16), .DRAIN_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .push_valid(push_valid), .push_entry(push_entry), .push_wr(push_wr),
    .push_size(push_size), .push_signed(push_signed), .push_addr(push_addr),
    .push_data(push_data), .full(full),
    .req_valid(req_valid), .req_entry(req_entry), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_entry(resp_entry), .resp_data(resp_data),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_value(cdb_value)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    exp_req_t er;
    exp_cdb_t ec;
    if (rst_in && rdy_in) begin
      if (req_valid) begin
        n_vec++;
        if (req_q.size() == 0) begin
          n_err++;
          $display("FAIL req_unexpected: got entry=%0d addr=%h at cyc %0d, required no request",
                   req_entry, req_addr, cyc);
        end else begin
          er = req_q.pop_front();
          if (req_entry !== er.entry || req_wr !== er.wr || req_size !== er.size ||
              req_addr !== er.addr || req_data !== er.data || cyc != er.cyc) begin
            n_err++;
            $display("FAIL req: got entry=%0d wr=%0d size=%0d addr=%h data=%h cyc=%0d, required entry=%0d wr=%0d size=%0d addr=%h data=%h cyc=%0d",
                     req_entry, req_wr, req_size, req_addr, req_data, cyc,
                     er.entry, er.wr, er.size, er.addr, er.data, er.cyc);
          end
        end
      end
      if (cdb_valid) begin
        n_vec++;
        if (cdb_q.size() == 0) begin
          n_err++;
          $display("FAIL cdb_unexpected: got entry=%0d value=%h at cyc %0d, required no result",
                   cdb_entry, cdb_value, cyc);
        end else begin
          ec = cdb_q.pop_front();
          if (cdb_entry !== ec.entry || cdb_value !== ec.value || cyc != ec.cyc) begin
            n_err++;
            $display("FAIL cdb: got entry=%0d value=%h cyc=%0d, required entry=%0d value=%h cyc=%0d",
                     cdb_entry, cdb_value, cyc, ec.entry, ec.value, ec.cyc);
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, expv);
    end
  endtask

  task automatic exp_req(input logic [4:0] e, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d, input int c);
    exp_req_t x;
    x.entry = e; x.wr = wr; x.size = sz; x.addr = a; x.data = d; x.cyc = c;
    req_q.push_back(x);
  endtask

  task automatic exp_cdb(input logic [4:0] e, input logic [31:0] v, input int c);
    exp_cdb_t x;
    x.entry = e; x.value = v; x.cyc = c;
    cdb_q.push_back(x);
  endtask

  task automatic set_push(input logic [4:0] e, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] d);
    push_valid = 1'b1; push_entry = e; push_wr = wr; push_size = sz;
    push_signed = sg; push_addr = a; push_data = d;
  endtask

  task automatic push_op(input logic [4:0] e, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d);
    set_push(e, wr, sz, sg, a, d);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic send_resp(input logic [4:0] e, input logic [31:0] d);
    resp_valid = 1'b1; resp_entry = e; resp_data = d;
    tick();
    resp_valid = 1'b0;
  endtask

  // Issue one load and answer it; optionally a wrong-tag response first.
  task automatic do_load(input logic [4:0] e, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] raw,
                         input logic [31:0] val, input logic bad_first);
    int t;
    t = cyc;
    exp_req(e, 1'b0, sz, a, 32'h0, t + 1);
    push_op(e, 1'b0, sz, sg, a, 32'hCAFE0000);
    if (bad_first) send_resp(e ^ 5'h1, 32'hFFFFFFFF);
    exp_cdb(e, val, cyc + 1);
    send_resp(e, raw);
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int r;
    int c;

    #2 rst_in = 1'b0;
    tick(); tick();
    check("reset_req_valid", req_valid, 0);
    check("reset_cdb_valid", cdb_valid, 0);
    check("reset_full",      full,      0);
    check("reset_req_addr",  req_addr,  0);
    check("reset_cdb_value", cdb_value, 0);
    rst_in = 1'b1;
    tick();

    // Word load, then byte/half formatting cases
    do_load(5'd3,  SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_load(5'd4,  SZ_BYTE, 1'b1, 32'h201, 32'h000000F0, 32'hFFFFFFF0, 1'b0);
    do_load(5'd4,  SZ_BYTE, 1'b0, 32'h201, 32'h000000F0, 32'h000000F0, 1'b0);
    do_load(5'd6,  SZ_HALF, 1'b1, 32'h202, 32'h00008001, 32'hFFFF8001, 1'b1);
    do_load(5'd7,  SZ_HALF, 1'b0, 32'h206, 32'h12348001, 32'h00008001, 1'b0);
    do_load(5'd8,  2'd3,    1'b1, 32'h20B, 32'h80000001, 32'h80000001, 1'b0);

    // Three stores then a load, back to back
    t = cyc;
    exp_req(5'd10, 1'b1, SZ_WORD, 32'h300, 32'h11111111, t + 1);
    exp_req(5'd11, 1'b1, SZ_HALF, 32'h302, 32'h22222222, t + 3);
    exp_req(5'd12, 1'b1, SZ_BYTE, 32'h305, 32'h33333333, t + 5);
    exp_req(5'd13, 1'b0, SZ_WORD, 32'h308, 32'h0,        t + 7);
    push_op(5'd10, 1'b1, SZ_WORD, 1'b0, 32'h300, 32'h11111111);
    push_op(5'd11, 1'b1, SZ_HALF, 1'b0, 32'h302, 32'h22222222);
    push_op(5'd12, 1'b1, SZ_BYTE, 1'b0, 32'h305, 32'h33333333);
    push_op(5'd13, 1'b0, SZ_WORD, 1'b0, 32'h308, 32'h44444444);
    while (cyc < t + 8) tick();
    exp_cdb(5'd13, 32'h12345678, cyc + 1);
    send_resp(5'd13, 32'h12345678);
    tick();

    // Fill to DEPTH behind a pending load
    t = cyc;
    exp_req(5'd1, 1'b0, SZ_WORD, 32'h500, 32'h0, t + 1);
    push_op(5'd1, 1'b0, SZ_WORD, 1'b0, 32'h500, 32'h0);
    for (int i = 0; i < 16; i++)
      push_op(5'(i), 1'b1, SZ_WORD, 1'b0, 32'h400 + 32'(4 * i), 32'hA0000000 + 32'(i));
    check("full_at_depth", full, 1);
    push_op(5'd31, 1'b1, SZ_WORD, 1'b0, 32'h7FC, 32'hDEAD0017);
    check("full_after_drop", full, 1);
    r = cyc;
    exp_cdb(5'd1, 32'hCAFEF00D, r + 1);
    for (int k = 0; k < 16; k++)
      exp_req(5'(k), 1'b1, SZ_WORD, 32'h400 + 32'(4 * k), 32'hA0000000 + 32'(k), r + 2 + 2 * k);
    send_resp(5'd1, 32'hCAFEF00D);
    tick();
    check("full_after_pop", full, 0);
    exp_req(5'd17, 1'b1, SZ_WORD, 32'h600, 32'hB0000017, r + 34);
    push_op(5'd17, 1'b1, SZ_WORD, 1'b0, 32'h600, 32'hB0000017);
    check("full_refilled", full, 1);
    exp_req(5'd18, 1'b1, SZ_WORD, 32'h604, 32'hB0000018, r + 36);
    push_op(5'd18, 1'b1, SZ_WORD, 1'b0, 32'h604, 32'hB0000018);
    check("full_push_pop", full, 1);
    while (cyc < r + 38) tick();

    // clear in WAIT; response two cycles later is swallowed
    t = cyc;
    exp_req(5'd5, 1'b0, SZ_WORD, 32'h800, 32'h0, t + 1);
    push_op(5'd5, 1'b0, SZ_WORD, 1'b0, 32'h800, 32'h0);
    push_op(5'd7, 1'b1, SZ_WORD, 1'b0, 32'h804, 32'h77777777);
    clear = 1'b1;
    set_push(5'd8, 1'b1, SZ_WORD, 1'b0, 32'h808, 32'h88888888);
    tick();
    clear = 1'b0;
    push_valid = 1'b0;
    exp_req(5'd6, 1'b1, SZ_BYTE, 32'h80C, 32'h00000066, t + 6);
    push_op(5'd6, 1'b1, SZ_BYTE, 1'b0, 32'h80C, 32'h00000066);
    send_resp(5'd5, 32'h55555555);
    while (cyc < t + 8) tick();

    // clear in WAIT with no response: DRAIN times out
    t = cyc;
    exp_req(5'd20, 1'b0, SZ_HALF, 32'h900, 32'h0, t + 1);
    push_op(5'd20, 1'b0, SZ_HALF, 1'b0, 32'h900, 32'h0);
    tick();
    c = cyc;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_req(5'd21, 1'b1, SZ_WORD, 32'h904, 32'h21212121, c + 18);
    push_op(5'd21, 1'b1, SZ_WORD, 1'b0, 32'h904, 32'h21212121);
    while (cyc < c + 20) tick();
    send_resp(5'd20, 32'h20202020);
    tick();

    // Stall: pending request pulse holds; pushes are ignored
    t = cyc;
    exp_req(5'd22, 1'b1, SZ_WORD, 32'hA00, 32'h0BADF00D, t + 3);
    push_op(5'd22, 1'b1, SZ_WORD, 1'b0, 32'hA00, 32'h0BADF00D);
    rdy_in = 1'b0;
    set_push(5'd23, 1'b1, SZ_WORD, 1'b0, 32'hA04, 32'h23232323);
    tick();
    check("stall_req_held", req_valid, 1);
    tick();
    push_valid = 1'b0;
    rdy_in = 1'b1;
    tick(); tick(); tick();

    // Reset in WAIT
    t = cyc;
    exp_req(5'd9, 1'b0, SZ_WORD, 32'hB00, 32'h0, t + 1);
    push_op(5'd9, 1'b0, SZ_WORD, 1'b0, 32'hB00, 32'h0);
    push_op(5'd14, 1'b1, SZ_WORD, 1'b0, 32'hB04, 32'hEEEE0000);
    rst_in = 1'b0;
    #1;
    check("rst_req_addr",  req_addr,  0);
    check("rst_req_entry", req_entry, 0);
    check("rst_cdb_value", cdb_value, 0);
    check("rst_cdb_entry", cdb_entry, 0);
    check("rst_full",      full,      0);
    tick();
    rst_in = 1'b1;
    send_resp(5'd9, 32'h99999999);
    tick();
    t = cyc;
    exp_req(5'd2, 1'b1, SZ_HALF, 32'hC00, 32'h00002222, t + 1);
    push_op(5'd2, 1'b1, SZ_HALF, 1'b0, 32'hC00, 32'h00002222);
    tick(); tick(); tick();

    for (int i = 0; i < 50 && (req_q.size() != 0 || cdb_q.size() != 0); i++) tick();
    while (req_q.size() != 0) begin
      exp_req_t x;
      x = req_q.pop_front();
      n_vec++; n_err++;
      $display("FAIL req_missing: got nothing, required entry=%0d addr=%h at cyc %0d", x.entry, x.addr, x.cyc);
    end
    while (cdb_q.size() != 0) begin
      exp_cdb_t y;
      y = cdb_q.pop_front();
      n_vec++; n_err++;
      $display("FAIL cdb_missing: got nothing, required entry=%0d value=%h at cyc %0d", y.entry, y.value, y.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
